jimmy_out_uart_tx: RTL and testbench
====================================

Name: jimmy_out_uart_tx

Overview:
Downstream consumer of one jimmy output port. Captures each byte the CPU writes with OUTPUT (data plus its one-cycle active-low out_strobe bit) into a small FIFO. Serialises the bytes as 8N1 UART frames. Returns a status byte that the team wires to a jimmy in_port, so firmware can poll FIFO state and overflow with INPUT.

Parameters:
CLKS_PER_BIT, 868, jimmy_clk cycles per UART bit (legal range 2..65535).
FIFO_DEPTH, 16, FIFO entries (power of 2, legal range 2..16).

Ports:
jimmy_clk  input  1  system clock; all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
port_data  input  8  connected to jimmy out_port_N.
port_strobe_n  input  1  connected to jimmy out_strobe[N]; low for one cycle per OUTPUT.
status_rd_n  input  1  connected to jimmy in_strobe[M]; low for one cycle per INPUT of the status port.
status  output  8  {ovf, full, empty, busy, count[3:0]}, to jimmy in_port_M.
tx  output  1  UART serial out, idle high.
busy  output  1  high while a frame is on the line.

Behaviour:
- Reset values (one edge with reset=1):
  - tx=1, busy=0, FIFO empty, count=0, ovf=0, FSM=IDLE.
  - strobe history registers = 1, so no false edge after reset.
  - Reset mid-frame aborts the frame immediately; tx=1 on the next cycle and the FIFO contents are discarded.
- Push:
  - Triggered on a falling edge of port_strobe_n: sampled 0 this edge and 1 the previous edge.
  - port_data is captured on that same edge.
  - A strobe held low for several cycles pushes exactly once.
- Full:
  - A push while count==FIFO_DEPTH is dropped and sets sticky ovf.
  - Exception: if a pop occurs on the same edge, the push is accepted and count stays at FIFO_DEPTH.
- ovf clear:
  - Cleared on a falling edge of status_rd_n, detected the same way as the push edge.
  - If a clear and a new overflow coincide, the overflow wins and ovf stays 1.
- status:
  - Registered. Reflects FIFO/FSM state after the previous edge.
  - Field definitions: empty = (count==0), full = (count==FIFO_DEPTH), count[3:0] = low bits of count (count==16 reads 0 with full=1), busy = FSM != IDLE.
- FSM states: IDLE, START, DATA, STOP. One bit-counter (0..CLKS_PER_BIT-1) and a 3-bit bit index.
  - IDLE: tx=1. If FIFO is non-empty, pop into the shift register and go to START. tx=0 from the next cycle.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: sends 8 bits LSB first, each held CLKS_PER_BIT cycles, then STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On the last cycle:
    - FIFO non-empty: pop and go straight to START (no idle gap).
    - Otherwise: go to IDLE.
- Latency and timing:
  - Push into an empty FIFO with FSM idle: tx falls 1 cycle after the push edge.
  - A frame is exactly 10*CLKS_PER_BIT cycles.
- Simultaneous events:
  - Push and pop on the same edge: count is unchanged and both take effect.
  - Push into an empty FIFO while IDLE: the byte is popped on the following edge, never on the same edge.
- FIFO storage:
  - Circular buffer with read and write pointers of log2(FIFO_DEPTH) bits, wrapping naturally.
  - count is log2(FIFO_DEPTH)+1 bits.
- Throughput ceiling: the CPU can issue an OUTPUT every 3 cycles, far faster than the line rate. Firmware must poll full; overflow is defined as above and never corrupts stored bytes.

Test Plan:
1. CLKS_PER_BIT=4; reset, then pulse strobe with data 0xA5 → tx low 1 cycle later. Bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop=1. Frame is 40 cycles; busy high for 40 cycles; status 0x20 before and after.
2. Push 0x01, 0x02, 0x03 on consecutive CPU OUTPUTs (3 cycles apart) → three back-to-back frames, 120 cycles, no idle gap. status.count reads 2, 1, 0 after each pop. empty=1 at the end.
3. FIFO_DEPTH=16; hold the FSM busy and push 17 bytes 0x10..0x20 → status = 0xD0 (ovf, full, busy, count 0). 0x20 is dropped; exactly 0x10..0x1F are transmitted in order.
4. Set ovf, then pulse status_rd_n → ovf=0 next cycle. Pulse status_rd_n on the same edge as an overflowing push → ovf stays 1.
5. Hold port_strobe_n low for 5 cycles with data 0x3C → exactly one push (count=1) and one frame.
6. Assert reset during DATA bit 3 of a frame with 4 bytes queued → tx=1 and busy=0 the next cycle, status=0x20. After release, no frame is sent without a new push.

Source files
------------

// File: rtl/jimmy_out_uart_tx.sv
// Output-port UART transmitter for jimmy: queues OUTPUT bytes in a FIFO and
// serialises them as 8N1 frames, exposing a pollable status byte.
module jimmy_out_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic       jimmy_clk,
    input  logic       reset,
    input  logic [7:0] port_data,
    input  logic       port_strobe_n,
    input  logic       status_rd_n,
    output logic [7:0] status,
    output logic       tx,
    output logic       busy
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = 16;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          strobe_q;
    logic          rd_q;
    logic          ovf;
    logic          ovf_next;
    logic          push;
    logic          clr;
    logic          full;
    logic          empty;
    logic          accept;
    logic          pop;

    state_t        state;
    state_t        state_next;
    logic [BW-1:0] baud;
    logic [BW-1:0] baud_next;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_next;
    logic [7:0]    shreg;
    logic [7:0]    shreg_next;
    logic          tx_next;

    // Falling-edge detection on the CPU strobes; history resets high.
    assign push  = strobe_q & ~port_strobe_n;
    assign clr   = rd_q & ~status_rd_n;
    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    // A push into a full FIFO survives only if a pop frees a slot on the same edge.
    assign accept     = push & (~full | pop);
    assign ovf_next   = (push & full & ~pop) | (ovf & ~clr);
    assign count_next = count + CW'(accept) - CW'(pop);

    // Frame sequencer; tx is registered from the next-state decision.
    always_comb begin
        state_next   = state;
        baud_next    = baud;
        bit_idx_next = bit_idx;
        shreg_next   = shreg;
        tx_next      = tx;
        pop          = 1'b0;
        case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (!empty) begin
                    pop        = 1'b1;
                    shreg_next = mem[rd_ptr];
                    baud_next  = '0;
                    tx_next    = 1'b0;
                    state_next = START;
                end
            end
            START: begin
                if (baud == BAUD_LAST) begin
                    baud_next    = '0;
                    bit_idx_next = '0;
                    tx_next      = shreg[0];
                    state_next   = DATA;
                end else begin
                    baud_next = baud + BW'(1);
                end
            end
            DATA: begin
                if (baud == BAUD_LAST) begin
                    baud_next = '0;
                    if (bit_idx == 3'd7) begin
                        tx_next    = 1'b1;
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                        shreg_next   = {1'b0, shreg[7:1]};
                        tx_next      = shreg[1];
                    end
                end else begin
                    baud_next = baud + BW'(1);
                end
            end
            STOP: begin
                if (baud == BAUD_LAST) begin
                    baud_next = '0;
                    if (!empty) begin
                        pop        = 1'b1;
                        shreg_next = mem[rd_ptr];
                        tx_next    = 1'b0;
                        state_next = START;
                    end else begin
                        tx_next    = 1'b1;
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud + BW'(1);
                end
            end
            default: begin
                tx_next    = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge jimmy_clk) begin
        if (reset) begin
            state    <= IDLE;
            baud     <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            strobe_q <= 1'b1;
            rd_q     <= 1'b1;
            status   <= 8'h20;
        end else begin
            state    <= state_next;
            baud     <= baud_next;
            bit_idx  <= bit_idx_next;
            shreg    <= shreg_next;
            tx       <= tx_next;
            busy     <= (state_next != IDLE);
            strobe_q <= port_strobe_n;
            rd_q     <= status_rd_n;
            count    <= count_next;
            ovf      <= ovf_next;
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop)    rd_ptr <= rd_ptr + AW'(1);
            // Status lags one edge: it snapshots the state left by the previous edge.
            status   <= {ovf, full, empty, (state != IDLE), 4'(count)};
        end
    end

    // Storage needs no reset; pointers and count define validity.
    always_ff @(posedge jimmy_clk) begin
        if (accept) mem[wr_ptr] <= port_data;
    end

endmodule

// File: tb/tb_jimmy_out_uart_tx.sv
// Self-checking bench for jimmy_out_uart_tx: a queue-and-timing reference model
// predicts tx/busy/status every cycle while scenario tasks drive the CPU side.
module tb_jimmy_out_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 16;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] port_data = 8'h00;
    logic       port_strobe_n = 1'b1;
    logic       status_rd_n = 1'b1;
    logic [7:0] status;
    logic       tx;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Reference model state
    byte unsigned mq[$];
    longint       cyc = 0;
    longint       f_start = 0;
    longint       f_end = 0;
    bit           f_valid = 1'b0;
    logic [7:0]   f_byte = 8'h00;
    bit           m_ovf = 1'b0;
    bit           m_sp = 1'b1;
    bit           m_rp = 1'b1;
    bit           m_busy = 1'b0;
    logic         exp_tx = 1'b1;
    logic         exp_busy = 1'b0;
    logic [7:0]   exp_status = 8'h20;

    jimmy_out_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .jimmy_clk    (clk),
        .reset        (reset),
        .port_data    (port_data),
        .port_strobe_n(port_strobe_n),
        .status_rd_n  (status_rd_n),
        .status       (status),
        .tx           (tx),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Model: FIFO as a queue; a frame popped at edge c occupies edges c..c+FRAME-1.
    task automatic model_loop();
        bit     push_e;
        bit     clr_e;
        bit     pop_e;
        bit     full_e;
        longint d;
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                mq.delete();
                m_ovf = 1'b0; m_sp = 1'b1; m_rp = 1'b1;
                f_valid = 1'b0; f_end = 0; m_busy = 1'b0;
                exp_status = 8'h20;
            end else begin
                exp_status = {m_ovf, (mq.size() == DEPTH), (mq.size() == 0), m_busy, 4'(mq.size())};
                push_e = m_sp && !port_strobe_n;
                clr_e  = m_rp && !status_rd_n;
                full_e = (mq.size() == DEPTH);
                pop_e  = (mq.size() != 0) && (cyc >= f_end);
                if (pop_e) begin
                    f_byte  = mq.pop_front();
                    f_start = cyc;
                    f_valid = 1'b1;
                    f_end   = cyc + FRAME;
                end
                if (push_e && (!full_e || pop_e)) mq.push_back(port_data);
                if (push_e && full_e && !pop_e) m_ovf = 1'b1;
                else if (clr_e)                 m_ovf = 1'b0;
                m_sp = port_strobe_n;
                m_rp = status_rd_n;
            end
            d = cyc - f_start;
            m_busy = f_valid && (d < FRAME);
            if (!m_busy)         exp_tx = 1'b1;
            else if (d < CPB)    exp_tx = 1'b0;
            else if (d >= 9*CPB) exp_tx = 1'b1;
            else                 exp_tx = f_byte[3'(d / CPB - 1)];
            exp_busy = m_busy;
        end
    endtask

    task automatic test_line_model();
        forever begin
            @(negedge clk);
            checks++;
            if (tx !== exp_tx) begin
                errors++;
                $display("FAIL line_tx cyc=%0d got=%b want=%b", cyc, tx, exp_tx);
            end
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL line_busy cyc=%0d got=%b want=%b", cyc, busy, exp_busy);
            end
            checks++;
            if (status !== exp_status) begin
                errors++;
                $display("FAIL line_status cyc=%0d got=%h want=%h", cyc, status, exp_status);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_strobe(input logic [7:0] d);
        @(negedge clk); port_data = d; port_strobe_n = 1'b0;
        @(negedge clk); port_strobe_n = 1'b1;
    endtask

    task automatic pulse_rd();
        @(negedge clk); status_rd_n = 1'b0;
        @(negedge clk); status_rd_n = 1'b1;
    endtask

    task automatic drain();
        idle((mq.size() + 1) * FRAME + 8);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(2);
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b want=1", tx); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++;
        if (status !== 8'h20) begin errors++; $display("FAIL reset_status got=%h want=20", status); end
        reset = 1'b0;
    endtask

    task automatic test_single();
        int         first_low = -1;
        int         busy_cnt = 0;
        logic [9:0] got = '0;
        logic [9:0] want = {1'b1, 8'hA5, 1'b0};
        checks++;
        if (status !== 8'h20) begin errors++; $display("FAIL single_pre_status got=%h want=20", status); end
        pulse_strobe(8'hA5);
        for (int t = 0; t < 50; t++) begin
            if (t > 0) @(negedge clk);
            if (tx === 1'b0 && first_low < 0) first_low = t;
            if (busy === 1'b1) busy_cnt++;
            for (int k = 0; k < 10; k++)
                if (t == 1 + CPB*k + CPB/2) got[k] = tx;
        end
        checks++;
        if (first_low != 1) begin errors++; $display("FAIL single_latency got=%0d want=1", first_low); end
        checks++;
        if (got !== want) begin errors++; $display("FAIL single_bits got=%b want=%b", got, want); end
        checks++;
        if (busy_cnt != FRAME) begin errors++; $display("FAIL single_busy_len got=%0d want=%0d", busy_cnt, FRAME); end
        checks++;
        if (status !== 8'h20) begin errors++; $display("FAIL single_post_status got=%h want=20", status); end
    endtask

    task automatic test_back_to_back();
        int busy_cnt = 0;
        int falls = 0;
        logic prev = 1'b1;
        pulse_strobe(8'h01); idle(1);
        pulse_strobe(8'h02); idle(1);
        pulse_strobe(8'h03); idle(2);
        checks++;
        if (status !== 8'h12) begin errors++; $display("FAIL b2b_queued_status got=%h want=12", status); end
        // Busy spans push edge +1 .. +120; this window starts 9 edges after the first push.
        for (int t = 0; t < 130; t++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (prev === 1'b1 && busy === 1'b0) falls++;
            prev = busy;
        end
        checks++;
        if (busy_cnt != 3*FRAME - 8) begin errors++; $display("FAIL b2b_busy_len got=%0d want=%0d", busy_cnt, 3*FRAME - 8); end
        checks++;
        if (falls != 1) begin errors++; $display("FAIL b2b_gaps got=%0d want=1", falls); end
        checks++;
        if (status !== 8'h20) begin errors++; $display("FAIL b2b_end_status got=%h want=20", status); end
    endtask

    task automatic test_overflow();
        pulse_strobe(8'hEE);
        for (int i = 0; i < 17; i++) pulse_strobe(8'(16 + i));
        idle(2);
        checks++;
        if (status !== 8'hD0) begin errors++; $display("FAIL ovf_status got=%h want=D0", status); end
        drain();
        checks++;
        if (status !== 8'hA0) begin errors++; $display("FAIL ovf_sticky got=%h want=A0", status); end
    endtask

    task automatic test_ovf_clear();
        pulse_rd(); idle(1);
        checks++;
        if (status !== 8'h20) begin errors++; $display("FAIL clr_status got=%h want=20", status); end
        pulse_strobe(8'hEE);
        for (int i = 0; i < 16; i++) pulse_strobe(8'(64 + i));
        @(negedge clk); port_data = 8'h77; port_strobe_n = 1'b0; status_rd_n = 1'b0;
        @(negedge clk); port_strobe_n = 1'b1; status_rd_n = 1'b1;
        idle(1);
        checks++;
        if (status !== 8'hD0) begin errors++; $display("FAIL clr_vs_ovf got=%h want=D0", status); end
        pulse_rd(); idle(1);
        checks++;
        if (status !== 8'h50) begin errors++; $display("FAIL clr_while_full got=%h want=50", status); end
        drain();
    endtask

    task automatic test_hold();
        int busy_cnt = 0;
        for (int t = 0; t < 70; t++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (t == 2) begin
                checks++;
                if (status !== 8'h01) begin errors++; $display("FAIL hold_count got=%h want=01", status); end
            end
            port_data = 8'h3C;
            port_strobe_n = (t < 5) ? 1'b0 : 1'b1;
        end
        checks++;
        if (busy_cnt != FRAME) begin errors++; $display("FAIL hold_frames busy_cycles got=%0d want=%0d", busy_cnt, FRAME); end
    endtask

    task automatic test_reset_mid();
        int busy_cnt = 0;
        int low_cnt = 0;
        pulse_strobe(8'h5A);
        for (int i = 0; i < 4; i++) pulse_strobe(8'(97 + i));
        idle(10);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL midrst_tx got=%b want=1", tx); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b want=0", busy); end
        checks++;
        if (status !== 8'h20) begin errors++; $display("FAIL midrst_status got=%h want=20", status); end
        for (int t = 0; t < 80; t++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (tx === 1'b0) low_cnt++;
        end
        checks++;
        if (busy_cnt != 0 || low_cnt != 0) begin
            errors++;
            $display("FAIL midrst_silent busy_cycles=%0d low_cycles=%0d want=0", busy_cnt, low_cnt);
        end
    endtask

    task automatic test_random();
        int gap;
        int hold;
        for (int i = 0; i < 80; i++) begin
            gap  = $urandom_range(1, 25);
            hold = $urandom_range(1, 3);
            @(negedge clk);
            port_data = 8'($urandom);
            port_strobe_n = 1'b0;
            status_rd_n = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
            repeat (hold) @(negedge clk);
            port_strobe_n = 1'b1;
            status_rd_n = 1'b1;
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                port_data = 8'($urandom);
            end
        end
        drain();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL random_drained busy got=%b want=0", busy); end
    endtask

    initial begin
        fork
            model_loop();
        join_none
        test_reset();
        fork
            test_line_model();
        join_none
        test_single();
        test_back_to_back();
        test_overflow();
        test_ovf_clear();
        test_hold();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
